// File: rtl/mips_mult_pipe.sv
// Pipelined 32x32 multiplier (P0..P3 + W) that owns the shared register-file write port.
// Optional macro MIPS_MULT_HI_EN adds the hi_we/hi_wdata outputs for the HI register.
module mips_mult_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int MULT_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mult_start_D,
  input  logic                  mult_signed_D,
  input  logic                  flush_D,
  input  logic [DATA_W-1:0]     src_a_D,
  input  logic [DATA_W-1:0]     src_b_D,
  input  logic [REG_ADDR_W-1:0] dest_addr_D,
  input  logic                  alu_we_W,
  input  logic [REG_ADDR_W-1:0] alu_addr_W,
  input  logic [DATA_W-1:0]     alu_data_W,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0]     reg_wdata,
  output logic                  mult_busy,
`ifdef MIPS_MULT_HI_EN
  output logic                  hi_we,
  output logic [DATA_W-1:0]     hi_wdata,
`endif
  output logic                  wb_collision
);

`ifdef MIPS_MULT_HI_EN
  localparam int PW = 2*DATA_W;
`else
  localparam int PW = DATA_W;
`endif

  // vld_pipe[0] = P0 ... vld_pipe[MULT_STAGES] = W
  logic [MULT_STAGES:0]                 vld_pipe;
  logic [MULT_STAGES:0][REG_ADDR_W-1:0] dest_pipe;
  logic [MULT_STAGES:1][PW-1:0]         prod_pipe;
  logic                                 sgn_p0;
  logic [DATA_W-1:0]                    a_p0, b_p0;
  logic                                 coll_q;

  logic                issue;
  logic [2*DATA_W-1:0] prod_full;
  logic                w_vld;
  logic [PW-1:0]       w_prod;

  assign issue = mult_start_D & ~flush_D;
  assign w_vld = vld_pipe[MULT_STAGES];
  assign w_prod = prod_pipe[MULT_STAGES];

  function automatic logic [2*DATA_W-1:0] ext(input logic [DATA_W-1:0] v, input logic s);
    return {{DATA_W{s & v[DATA_W-1]}}, v};
  endfunction

  // Full-width product of extended operands; truncation yields the MULT/MULTU result.
  assign prod_full = ext(a_p0, sgn_p0) * ext(b_p0, sgn_p0);

`ifndef MIPS_MULT_HI_EN
  logic [DATA_W-1:0] prod_hi_unused;
  assign prod_hi_unused = prod_full[2*DATA_W-1:DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe  <= '0;
      dest_pipe <= '0;
      prod_pipe <= '0;
      sgn_p0    <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      coll_q    <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[MULT_STAGES-1:0], issue};
      dest_pipe <= {dest_pipe[MULT_STAGES-1:0], dest_addr_D};
      if (issue) begin
        sgn_p0 <= mult_signed_D;
        a_p0   <= src_a_D;
        b_p0   <= src_b_D;
      end
      prod_pipe[1] <= prod_full[PW-1:0];
      for (int i = 2; i <= MULT_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
      if (w_vld && alu_we_W) coll_q <= 1'b1;
    end
  end

  // Multiplier has priority; $zero is never written by either source.
  always_comb begin
    reg_we       = 1'b0;
    reg_waddr    = '0;
    reg_wdata    = '0;
    mult_busy    = 1'b0;
    wb_collision = 1'b0;
    if (rst) begin
      if (w_vld) begin
        reg_waddr = dest_pipe[MULT_STAGES];
        reg_wdata = w_prod[DATA_W-1:0];
        reg_we    = 1'b1;
      end else if (alu_we_W) begin
        reg_waddr = alu_addr_W;
        reg_wdata = alu_data_W;
        reg_we    = 1'b1;
      end
      if (reg_waddr == '0) reg_we = 1'b0;
      mult_busy    = |vld_pipe;
      wb_collision = coll_q;
    end
  end

`ifdef MIPS_MULT_HI_EN
  assign hi_we    = rst & w_vld;
  assign hi_wdata = (rst & w_vld) ? w_prod[PW-1:DATA_W] : '0;
`endif

endmodule

// File: tb/tb_mips_mult_pipe.sv
// Scoreboard bench for mips_mult_pipe: issued multiplies are queued with their due cycle,
// a negedge monitor compares the write port, busy and collision flags every cycle.
module tb_mips_mult_pipe;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mult_start_D = 1'b0, mult_signed_D = 1'b0, flush_D = 1'b0;
  logic [31:0] src_a_D = '0, src_b_D = '0;
  logic [4:0]  dest_addr_D = '0;
  logic        alu_we_W = 1'b0;
  logic [4:0]  alu_addr_W = '0;
  logic [31:0] alu_data_W = '0;
  logic        reg_we, mult_busy, wb_collision;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
`ifdef MIPS_MULT_HI_EN
  logic        hi_we;
  logic [31:0] hi_wdata;
`endif

  mips_mult_pipe dut (
    .clk(clk), .rst(rst),
    .mult_start_D(mult_start_D), .mult_signed_D(mult_signed_D), .flush_D(flush_D),
    .src_a_D(src_a_D), .src_b_D(src_b_D), .dest_addr_D(dest_addr_D),
    .alu_we_W(alu_we_W), .alu_addr_W(alu_addr_W), .alu_data_W(alu_data_W),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mult_busy(mult_busy),
`ifdef MIPS_MULT_HI_EN
    .hi_we(hi_we), .hi_wdata(hi_wdata),
`endif
    .wb_collision(wb_collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [4:0]  dest;
    logic [63:0] prod;
  } exp_t;
  exp_t q[$];

  int compared = 0, mismatched = 0;
  bit coll_m = 1'b0;

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = $signed(a); sb = $signed(b);
      return sa * sb;
    end
    ua = a; ub = b;
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One input cycle; accepted multiplies are queued with their W-stage cycle.
  task automatic step(input logic r, input logic st, input logic sg, input logic fl,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                      input logic awe, input logic [4:0] aad, input logic [31:0] adat);
    exp_t e;
    @(posedge clk); #1;
    rst = r; mult_start_D = st; mult_signed_D = sg; flush_D = fl;
    src_a_D = a; src_b_D = b; dest_addr_D = d;
    alu_we_W = awe; alu_addr_W = aad; alu_data_W = adat;
    if (r && st && !fl) begin
      e.due = cyc + LAT; e.dest = d; e.prod = ref_mul(sg, a, b);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd0, 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t it;
    bit mv, busy, ewe;
    logic [4:0]  eaddr;
    logic [31:0] edata;
    mv = 0; busy = 0;
    foreach (q[i]) if (q[i].due <= cyc + LAT - 1) busy = 1;
    if (q.size() > 0 && q[0].due == cyc) begin
      it = q.pop_front(); mv = 1;
    end
    if (!rst) begin
      chk("rst_we", reg_we, 0);
      chk("rst_waddr", reg_waddr, 0);
      chk("rst_wdata", reg_wdata, 0);
      chk("rst_busy", mult_busy, 0);
      chk("rst_coll", wb_collision, 0);
`ifdef MIPS_MULT_HI_EN
      chk("rst_hi_we", hi_we, 0);
      chk("rst_hi_wdata", hi_wdata, 0);
`endif
      q.delete();
      coll_m = 0;
    end else begin
      ewe = 0; eaddr = '0; edata = '0;
      if (mv) begin
        eaddr = it.dest; edata = it.prod[31:0]; ewe = (it.dest != 0);
      end else if (alu_we_W) begin
        eaddr = alu_addr_W; edata = alu_data_W; ewe = (alu_addr_W != 0);
      end
      chk("reg_we", reg_we, ewe);
      if (ewe) begin
        chk("reg_waddr", reg_waddr, eaddr);
        chk("reg_wdata", reg_wdata, edata);
      end
      chk("mult_busy", mult_busy, busy);
      chk("wb_collision", wb_collision, coll_m);
`ifdef MIPS_MULT_HI_EN
      chk("hi_we", hi_we, mv);
      if (mv) chk("hi_wdata", hi_wdata, it.prod[63:32]);
`endif
      if (mv && alu_we_W) coll_m = 1;
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 5'd3, 32'h1234);
    // signed 7 * -3 -> dest 5
    step(1, 1, 1, 0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 5'd0, 32'h0);
    idle(6);
    // unsigned and signed 0xFFFFFFFF * 2 -> dest 8
    step(1, 1, 0, 0, 32'hFFFF_FFFF, 32'd2, 5'd8, 0, 5'd0, 32'h0);
    step(1, 1, 1, 0, 32'hFFFF_FFFF, 32'd2, 5'd8, 0, 5'd0, 32'h0);
    idle(6);
    // four back-to-back issues
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, i, 32'd3, 5'(i), 0, 5'd0, 32'h0);
    idle(6);
    // ALU write colliding with a multiplier W stage
    step(1, 1, 0, 0, 32'd2, 32'd5, 5'd9, 0, 5'd0, 32'h0);
    idle(4);
    step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 5'd10, 32'h55);
    idle(3);
    // flushed issue, then multiply into $zero
    step(1, 1, 0, 1, 32'd6, 32'd6, 5'd7, 0, 5'd0, 32'h0);
    idle(6);
    step(1, 1, 0, 0, 32'd6, 32'd6, 5'd0, 0, 5'd0, 32'h0);
    idle(6);
    // reset with two multiplies in flight, then a clean issue
    step(1, 1, 0, 0, 32'd11, 32'd3, 5'd12, 0, 5'd0, 32'h0);
    step(1, 1, 1, 0, 32'd13, 32'd3, 5'd13, 0, 5'd0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 5'd0, 32'h0);
    idle(6);
    step(1, 1, 1, 0, 32'hFFFF_FFF0, 32'd4, 5'd14, 0, 5'd0, 32'h0);
    idle(6);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 1) == 1), 1'($urandom),
           ($urandom_range(0, 99) < 15), $urandom, $urandom, 5'($urandom),
           1'($urandom), 5'($urandom), $urandom);
    idle(8);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
